// File: rtl/dvs_event_uart_sender_pkg.sv
// dvs_event_uart_sender_pkg: link byte codes, event record and TX state encoding
package dvs_event_uart_sender_pkg;
    localparam logic [7:0] CMD_PING    = 8'hFF;
    localparam logic [7:0] CMD_QUERY   = 8'hFE;
    localparam logic [7:0] RSP_PONG    = 8'h55;
    localparam logic [4:0] RSP_BIN_HI  = 5'h16;
    localparam logic [5:0] RSP_GEST_HI = 6'h28;
    typedef struct packed {
        logic [8:0] x;
        logic [8:0] y;
        logic       pol;
    } event_t;
    typedef enum logic [2:0] {S_IDLE, S_CMD, S_EV0, S_EV1, S_EV2, S_EV3, S_EV4} tx_state_e;
    function automatic logic [7:0] ev_byte(input event_t e, input tx_state_e s);
        return s == S_EV0 ? {7'b0, e.x[8]} :
               s == S_EV1 ? e.x[7:0] :
               s == S_EV2 ? {7'b0, e.y[8]} :
               s == S_EV3 ? e.y[7:0] : {7'b0, e.pol};
    endfunction
endpackage

// File: rtl/dvs_event_fifo.sv
// dvs_event_fifo: synchronous event FIFO; ready is registered from the next-state count
module dvs_event_fifo
    import dvs_event_uart_sender_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push_i,
    input  event_t din_i,
    input  logic   pop_i,
    output event_t dout_o,
    output logic   empty_o,
    output logic   ready_o
);
    localparam int AW = $clog2(DEPTH);
    event_t        mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ready_q, do_push;
    assign do_push = push_i && ready_q;
    assign cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(pop_i);
    assign dout_o  = mem_q[rp_q];
    assign empty_o = cnt_q == '0;
    assign ready_o = ready_q;
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q] <= din_i;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            wp_q    <= wp_q + AW'(do_push);
            rp_q    <= rp_q + AW'(pop_i);
            cnt_q   <= cnt_d;
            ready_q <= cnt_d != (AW+1)'(DEPTH);
        end
    end
endmodule

// File: rtl/dvs_event_uart_sender.sv
// dvs_event_uart_sender: buffers DVS events into 5-byte UART packets, issues PING/QUERY
// and decodes the accelerator's replies with a response timeout.
module dvs_event_uart_sender
    import dvs_event_uart_sender_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ev_valid,
    input  logic [8:0] ev_x,
    input  logic [8:0] ev_y,
    input  logic       ev_pol,
    output logic       ev_ready,
    input  logic       cmd_ping,
    input  logic       cmd_query,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_busy,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       pong,
    output logic       bin_valid,
    output logic [2:0] bin,
    output logic       gesture_valid,
    output logic [1:0] gesture,
    output logic       resp_timeout,
    output logic       rx_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    tx_state_e     state_q;
    event_t        ev_q, head;
    logic [7:0]    cmd_q, tx_data_q;
    logic [TW-1:0] tmr_q;
    logic [2:0]    bin_q;
    logic [1:0]    gesture_q;
    logic          ping_pend_q, query_pend_q, out_q, out_qry_q;
    logic          tx_valid_q, pong_q, bin_valid_q, gest_valid_q, timeout_q, rx_err_q;
    logic          empty, can_send, pop, is_pong, is_bin, is_gest;
    // the previous-strobe guard hides the transmitter's one-cycle busy latency
    assign can_send = !tx_busy && !tx_valid_q;
    assign pop      = state_q == S_EV0 && can_send;
    assign is_pong  = rx_data == RSP_PONG;
    assign is_bin   = rx_data[7:3] == RSP_BIN_HI;
    assign is_gest  = rx_data[7:2] == RSP_GEST_HI;
    dvs_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (ev_valid),
        .din_i   (event_t'({ev_x, ev_y, ev_pol})),
        .pop_i   (pop),
        .dout_o  (head),
        .empty_o (empty),
        .ready_o (ev_ready)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ev_q         <= '0;
            cmd_q        <= '0;
            tx_data_q    <= '0;
            tmr_q        <= '0;
            bin_q        <= '0;
            gesture_q    <= '0;
            ping_pend_q  <= 1'b0;
            query_pend_q <= 1'b0;
            out_q        <= 1'b0;
            out_qry_q    <= 1'b0;
            tx_valid_q   <= 1'b0;
            pong_q       <= 1'b0;
            bin_valid_q  <= 1'b0;
            gest_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
            rx_err_q     <= 1'b0;
        end else begin
            tx_valid_q   <= 1'b0;
            pong_q       <= 1'b0;
            bin_valid_q  <= 1'b0;
            gest_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
            rx_err_q     <= 1'b0;
            if (out_q) begin
                if (tmr_q == '0) begin
                    out_q     <= 1'b0;
                    timeout_q <= 1'b1;
                end else tmr_q <= tmr_q - 1'b1;
            end
            if (rx_valid) begin
                pong_q       <= is_pong;
                bin_valid_q  <= is_bin;
                gest_valid_q <= is_gest;
                rx_err_q     <= !(is_pong || is_bin || is_gest);
                if (is_bin) bin_q <= rx_data[2:0];
                if (is_gest) gesture_q <= rx_data[1:0];
                // a matching reply beats a timeout expiring in the same cycle
                if (out_q && ((is_pong && !out_qry_q) || (is_bin && out_qry_q))) begin
                    out_q     <= 1'b0;
                    timeout_q <= 1'b0;
                end
            end
            case (state_q)
                S_IDLE: begin
                    if (!out_q && (ping_pend_q || query_pend_q)) begin
                        state_q <= S_CMD;
                        cmd_q   <= ping_pend_q ? CMD_PING : CMD_QUERY;
                    end else if (!empty) state_q <= S_EV0;
                end
                S_CMD: begin
                    if (can_send) begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= cmd_q;
                        out_q      <= 1'b1;
                        out_qry_q  <= cmd_q == CMD_QUERY;
                        tmr_q      <= TW'(TIMEOUT_CYCLES - 1);
                        if (cmd_q == CMD_PING) ping_pend_q <= 1'b0;
                        else query_pend_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                default: begin
                    if (can_send) begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= ev_byte(state_q == S_EV0 ? head : ev_q, state_q);
                        if (state_q == S_EV0) ev_q <= head;
                        state_q    <= state_q == S_EV4 ? S_IDLE : tx_state_e'(state_q + 3'd1);
                    end
                end
            endcase
            if (cmd_ping) ping_pend_q <= 1'b1;
            if (cmd_query) query_pend_q <= 1'b1;
        end
    end
    assign tx_data       = tx_data_q;
    assign tx_valid      = tx_valid_q;
    assign pong          = pong_q;
    assign bin_valid     = bin_valid_q;
    assign bin           = bin_q;
    assign gesture_valid = gest_valid_q;
    assign gesture       = gesture_q;
    assign resp_timeout  = timeout_q;
    assign rx_err        = rx_err_q;
endmodule

// File: tb/tb_dvs_event_uart_sender.sv
// tb_dvs_event_uart_sender: randomized scoreboard bench with a transmitter busy model
module tb_dvs_event_uart_sender;
    localparam int TMO = 100;
    typedef struct {int kind; int val;} rsp_t;
    logic       clk = 1'b0, rst_n = 1'b0, ev_valid = 1'b0, ev_pol = 1'b0;
    logic       cmd_ping = 1'b0, cmd_query = 1'b0, tx_busy = 1'b0, rx_valid = 1'b0;
    logic [8:0] ev_x = '0, ev_y = '0;
    logic [7:0] rx_data = '0, tx_data;
    logic       ev_ready, tx_valid, pong, bin_valid, gesture_valid, resp_timeout, rx_err;
    logic [2:0] bin;
    logic [1:0] gesture;
    logic [7:0] ev_exp[$], cmd_exp[$];
    rsp_t       rsp_exp[$];
    rsp_t       me;
    int         tests = 0, errors = 0, cyc = 0, pos = 0, busy_cnt = 0, busy_len = 2, deadline = 0, mk = 0;
    bit         hold = 0, last_strobe = 0, model_out = 0, model_qry = 0, acc;

    dvs_event_uart_sender #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .ev_valid(ev_valid), .ev_x(ev_x), .ev_y(ev_y), .ev_pol(ev_pol),
        .ev_ready(ev_ready), .cmd_ping(cmd_ping), .cmd_query(cmd_query), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_busy(tx_busy), .rx_data(rx_data), .rx_valid(rx_valid), .pong(pong),
        .bin_valid(bin_valid), .bin(bin), .gesture_valid(gesture_valid), .gesture(gesture),
        .resp_timeout(resp_timeout), .rx_err(rx_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic fail(input string name, input int got);
        tests++;
        errors++;
        $display("FAIL %s: got %0d, expected the awaited condition", name, got);
    endtask

    function automatic rsp_t classify(input logic [7:0] b);
        rsp_t r;
        r.val = 0;
        if (b == 8'h55) r.kind = 1;
        else if (b >= 8'hB0 && b <= 8'hB7) begin r.kind = 2; r.val = int'(b - 8'hB0); end
        else if (b >= 8'hA0 && b <= 8'hA3) begin r.kind = 3; r.val = int'(b - 8'hA0); end
        else r.kind = 4;
        return r;
    endfunction

    // monitor + transmitter model: busy rises one cycle after a strobe, lasts busy_len cycles
    always @(negedge clk) begin
        if (!rst_n) begin
            pos = 0;
            last_strobe = 0;
            busy_cnt = 0;
            tx_busy = hold;
        end else begin
            if (model_out && cyc == deadline) begin
                chk("resp_timeout_pulse", {31'b0, resp_timeout}, 1);
                model_out = 0;
            end else if (resp_timeout) chk("resp_timeout_spurious", {31'b0, resp_timeout}, 0);
            if (tx_valid) begin
                chk("strobe_while_busy", {31'b0, tx_busy}, 0);
                chk("strobe_back_to_back", {31'b0, last_strobe}, 0);
                if (pos == 0 && tx_data >= 8'hFE) begin
                    if (cmd_exp.size() == 0) fail("cmd_unexpected", int'(tx_data));
                    else chk("cmd_byte", tx_data, cmd_exp.pop_front());
                    chk("cmd_while_outstanding", {31'b0, model_out}, 0);
                    model_out = 1;
                    model_qry = tx_data == 8'hFE;
                    deadline = cyc + TMO;
                end else begin
                    if (ev_exp.size() == 0) fail("ev_unexpected", int'(tx_data));
                    else chk("ev_byte", tx_data, ev_exp.pop_front());
                    pos = pos == 4 ? 0 : pos + 1;
                end
            end
            last_strobe = tx_valid;
            if (busy_cnt > 0) busy_cnt--;
            if (tx_valid) busy_cnt = busy_len + 1;
            tx_busy = hold || (busy_cnt > 0 && busy_cnt <= busy_len);
            if (pong || bin_valid || gesture_valid || rx_err) begin
                mk = pong ? 1 : bin_valid ? 2 : gesture_valid ? 3 : 4;
                chk("rsp_onehot", $countones({pong, bin_valid, gesture_valid, rx_err}), 1);
                if (rsp_exp.size() == 0) fail("rsp_unexpected", mk);
                else begin
                    me = rsp_exp.pop_front();
                    chk("rsp_kind", mk, me.kind);
                    if (mk == 2) chk("bin_value", {29'b0, bin}, me.val);
                    if (mk == 3) chk("gesture_value", {30'b0, gesture}, me.val);
                end
            end
        end
    end

    task automatic push_ev(input logic [8:0] x, input logic [8:0] y, input logic p, output bit a);
        @(negedge clk);
        ev_x = x; ev_y = y; ev_pol = p; ev_valid = 1'b1;
        a = ev_ready;
        if (a) begin
            ev_exp.push_back(8'(x / 9'd256));
            ev_exp.push_back(8'(x % 9'd256));
            ev_exp.push_back(8'(y / 9'd256));
            ev_exp.push_back(8'(y % 9'd256));
            ev_exp.push_back({7'b0, p});
        end
        @(posedge clk);
        #1 ev_valid = 1'b0;
    endtask

    task automatic ev_retry(input logic [8:0] x, input logic [8:0] y, input logic p);
        bit a;
        for (int i = 0; i < 3000; i++) begin
            push_ev(x, y, p, a);
            if (a) return;
        end
        fail("ev_accept_timeout", 0);
    endtask

    task automatic pulse(input bit q);
        @(negedge clk);
        if (q) begin cmd_query = 1'b1; cmd_exp.push_back(8'hFE); end
        else begin cmd_ping = 1'b1; cmd_exp.push_back(8'hFF); end
        @(negedge clk);
        cmd_ping = 1'b0;
        cmd_query = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rsp_t r;
        r = classify(b);
        @(negedge clk);
        rx_data = b;
        rx_valid = 1'b1;
        rsp_exp.push_back(r);
        if (model_out && ((r.kind == 1 && !model_qry) || (r.kind == 2 && model_qry))) model_out = 0;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_out(input bit v, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (model_out == v) return;
            @(negedge clk);
        end
        fail(name, int'(model_out));
    endtask

    task automatic wait_pos(input int p, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (pos == p) return;
        end
        fail("wait_packet_position", pos);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ev_exp.size() == 0 && cmd_exp.size() == 0 && !model_out) begin
                repeat (busy_len + 4) @(negedge clk);
                return;
            end
        end
        fail("drain_timeout", ev_exp.size() + cmd_exp.size());
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", {12'b0, tx_valid, ev_ready, pong, bin_valid, gesture_valid, resp_timeout,
                              rx_err, tx_data, bin, gesture}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {31'b0, ev_ready}, 1);

        busy_len = 1040;
        push_ev(9'h13A, 9'h005, 1'b1, acc);
        chk("single_accept", {31'b0, acc}, 1);
        drain(8000);

        busy_len = 3;
        hold = 1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            push_ev(9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)), 1'($urandom), acc);
            chk("fill_accept", {31'b0, acc}, 1);
        end
        chk("full_ready", {31'b0, ev_ready}, 0);
        push_ev(9'h1FF, 9'h1FF, 1'b1, acc);
        chk("fifth_refused", {31'b0, acc}, 0);
        hold = 0;
        for (int i = 0; i < 50 && !tx_valid; i++) @(negedge clk);
        chk("ready_after_pop", {30'b0, tx_valid, ev_ready}, 3);
        drain(500);

        busy_len = 20;
        ev_retry(9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)), 1'($urandom));
        wait_pos(2, 500);
        pulse(0);
        wait_out(1, 1000, "ping_sent");
        chk("ping_after_packet", ev_exp.size(), 0);
        repeat (5) @(negedge clk);
        rx_byte(8'h55);
        repeat (TMO + 20) @(negedge clk);
        drain(500);

        busy_len = 2;
        pulse(1);
        wait_out(1, 200, "query_sent");
        mk = cyc;
        pulse(1);
        wait_out(0, 300, "query_timeout");
        wait_out(1, 50, "second_query_sent");
        chk("second_query_delay", {31'b0, cyc - mk >= TMO}, 1);
        wait_out(0, 300, "second_query_timeout");
        repeat (5) @(negedge clk);

        rx_byte(8'hB5);
        rx_byte(8'hA2);
        rx_byte(8'h7C);
        repeat (2) @(negedge clk);
        chk("bin_hold", {29'b0, bin}, 5);
        chk("gesture_hold", {30'b0, gesture}, 2);
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 3))
                0: rx_byte(8'h55);
                1: rx_byte(8'hB0 + 8'($urandom_range(0, 7)));
                2: rx_byte(8'hA0 + 8'($urandom_range(0, 3)));
                default: rx_byte(8'($urandom_range(0, 255)));
            endcase
        end

        pulse(1);
        wait_out(1, 100, "query2_sent");
        repeat (3) @(negedge clk);
        rx_byte(8'h55);
        wait_out(0, 200, "mismatch_timeout");
        pulse(1);
        wait_out(1, 100, "query3_sent");
        repeat (3) @(negedge clk);
        rx_byte(8'hB3);
        repeat (TMO + 20) @(negedge clk);

        for (int i = 0; i < 24; i++) begin
            busy_len = $urandom_range(0, 5);
            if ($urandom_range(0, 5) == 0 && cmd_exp.size() == 0 && !model_out) pulse(0);
            ev_retry(9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)), 1'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain(3000);

        busy_len = 20;
        ev_retry(9'h0AB, 9'h1CD, 1'b0);
        wait_pos(3, 500);
        for (int i = 0; i < 100 && !tx_valid; i++) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 chk("reset_kills_strobe", {30'b0, tx_valid, ev_ready}, 0);
        ev_exp.delete();
        cmd_exp.delete();
        model_out = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_mid_reset", {31'b0, ev_ready}, 1);
        ev_retry(9'h101, 9'h0FE, 1'b1);
        drain(1000);

        chk("rsp_queue_empty", rsp_exp.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
